sram_req_arbiter_2x1: RTL and testbench

- Shares one SRAM-like request port between the instruction-fetch requester and the uncached/wrapped data requester.
- The shared port feeds the AXI interface wrapper.
- Arbitrates requests, holds a grant stable until the address is accepted, and tracks outstanding transactions in order.
- Routes each in-order data_ok/rdata response back to the requester that issued it.

---
 rtl/sram_req_arbiter_2x1.sv | 126 ++++++++++++
 tb/tb_sram_req_arbiter_2x1.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter_2x1.sv
// Two-to-one SRAM-like request arbiter in front of the AXI wrapper.
// Tracks accepted requests in order and steers each response home.
module sram_req_arbiter_2x1 #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [DEPTH-1:0] tag_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             lock;
  logic             lock_owner;
  logic [SW-1:0]    starve_cnt;

  logic grant;
  logic full;
  logic accept;
  logic pop;
  logic head;

  // grant: 0 selects inst, 1 selects data
  always_comb begin
    grant = 1'b0;
    if (lock)
      grant = lock_owner;
    else if (inst_req && data_req && starve_cnt == SW'(STARVE_MAX))
      grant = 1'b0;
    else if (data_req)
      grant = 1'b1;
  end

  assign full      = (count == CW'(DEPTH));
  assign mem_req   = (inst_req | data_req) & ~full;
  assign mem_wr    = grant ? data_wr    : inst_wr;
  assign mem_size  = grant ? data_size  : inst_size;
  assign mem_addr  = grant ? data_addr  : inst_addr;
  assign mem_wdata = grant ? data_wdata : inst_wdata;

  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & ~grant;
  assign data_addr_ok = accept & grant;

  assign pop          = mem_data_ok & (count != '0);
  assign head         = tag_q[rd_ptr];
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        tag_q[wr_ptr] <= grant;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop)
        count <= count + CW'(1);
      else if (!accept && pop)
        count <= count - CW'(1);
    end
  end

  // a stalled request keeps its owner until the port takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock       <= 1'b0;
      lock_owner <= 1'b0;
    end else if (mem_addr_ok) begin
      lock <= 1'b0;
    end else if (mem_req) begin
      lock       <= 1'b1;
      lock_owner <= grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (!grant)
        starve_cnt <= '0;
      else if (inst_req && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter_2x1.sv
// Directed and randomized bench for sram_req_arbiter_2x1 against a
// queue-based reference model.
module tb_sram_req_arbiter_2x1;

  localparam int DEPTH  = 4;
  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  sram_req_arbiter_2x1 #(.DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: ordered owners of outstanding transactions, held owner, streak
  bit tq[$];
  int held;
  int streak;

  bit          e_g, e_mreq, e_acc, e_pop;
  bit          e_iaok, e_daok, e_idok, e_ddok;
  logic [31:0] e_irdata, e_drdata;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    tq.delete();
    held   = -1;
    streak = 0;
  endfunction

  function automatic void model_eval();
    bit hd;
    if (held >= 0)
      e_g = (held == 1);
    else if (inst_req && data_req && streak == STARVE)
      e_g = 1'b0;
    else
      e_g = data_req;
    e_mreq   = (inst_req || data_req) && (tq.size() < DEPTH);
    e_acc    = e_mreq && mem_addr_ok;
    e_iaok   = e_acc && !e_g;
    e_daok   = e_acc && e_g;
    e_pop    = mem_data_ok && (tq.size() > 0);
    hd       = e_pop ? tq[0] : 1'b0;
    e_idok   = e_pop && !hd;
    e_ddok   = e_pop && hd;
    e_irdata = e_idok ? mem_rdata : 32'h0;
    e_drdata = e_ddok ? mem_rdata : 32'h0;
  endfunction

  function automatic void compare();
    chk("mem_req", {31'b0, mem_req}, {31'b0, e_mreq});
    chk("mem_addr", mem_addr, e_g ? data_addr : inst_addr);
    chk("mem_wdata", mem_wdata, e_g ? data_wdata : inst_wdata);
    chk("mem_size", {30'b0, mem_size}, {30'b0, e_g ? data_size : inst_size});
    chk("mem_wr", {31'b0, mem_wr}, {31'b0, e_g ? data_wr : inst_wr});
    chk("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, e_iaok});
    chk("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, e_daok});
    chk("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, e_idok});
    chk("data_data_ok", {31'b0, data_data_ok}, {31'b0, e_ddok});
    chk("inst_rdata", inst_rdata, e_irdata);
    chk("data_rdata", data_rdata, e_drdata);
  endfunction

  function automatic void model_update();
    if (rst) return;
    if (e_pop) void'(tq.pop_front());
    if (e_acc) tq.push_back(e_g);
    if (mem_addr_ok) held = -1;
    else if (e_mreq) held = e_g ? 1 : 0;
    if (e_acc) begin
      if (!e_g) streak = 0;
      else if (inst_req && streak < STARVE) streak++;
    end
  endfunction

  task automatic settle();
    @(negedge clk);
    model_eval();
    compare();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 0; data_req = 0;
    mem_addr_ok = 0; mem_data_ok = 0;
    mem_rdata = 32'h0;
  endtask

  task automatic drain(int n);
    idle();
    mem_data_ok = 1;
    for (int i = 0; i < n; i++) begin
      mem_rdata = $urandom;
      settle();
      advance();
    end
    mem_data_ok = 0;
  endtask

  logic [7:0] pat;
  bit ip, dp;

  initial begin
    rst = 1;
    inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
    data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("reset_mem_req", {31'b0, mem_req}, 32'h0);
    chk("reset_inst_data_ok", {31'b0, inst_data_ok}, 32'h0);
    advance();
    rst = 0;

    // inst-only read
    inst_req = 1; inst_addr = 32'h1FC00000; mem_addr_ok = 1;
    settle();
    chk("t1_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h1);
    chk("t1_mem_addr", mem_addr, 32'h1FC00000);
    advance();
    idle();
    settle(); advance();
    mem_data_ok = 1; mem_rdata = 32'h3C000000;
    settle();
    chk("t1_inst_data_ok", {31'b0, inst_data_ok}, 32'h1);
    chk("t1_inst_rdata", inst_rdata, 32'h3C000000);
    chk("t1_data_data_ok", {31'b0, data_data_ok}, 32'h0);
    advance();

    // simultaneous requests: data first, then inst
    idle();
    inst_req = 1; inst_addr = 32'h1FC00010;
    data_req = 1; data_addr = 32'h80000020; data_wr = 1; data_wdata = 32'hCAFEF00D;
    mem_addr_ok = 1;
    settle();
    chk("t2_data_first", {31'b0, data_addr_ok}, 32'h1);
    chk("t2_mem_addr_d", mem_addr, 32'h80000020);
    chk("t2_mem_wdata", mem_wdata, 32'hCAFEF00D);
    advance();
    data_req = 0; data_wr = 0;
    settle();
    chk("t2_inst_second", {31'b0, inst_addr_ok}, 32'h1);
    advance();
    idle();
    mem_data_ok = 1; mem_rdata = 32'h11111111;
    settle();
    chk("t2_resp_data", {31'b0, data_data_ok}, 32'h1);
    chk("t2_resp_data_rd", data_rdata, 32'h11111111);
    advance();
    mem_rdata = 32'h22222222;
    settle();
    chk("t2_resp_inst", {31'b0, inst_data_ok}, 32'h1);
    chk("t2_resp_inst_rd", inst_rdata, 32'h22222222);
    advance();

    // stall with data granted; inst arrives mid-stall
    idle();
    data_req = 1; data_addr = 32'hBFAF8000;
    settle(); advance();
    inst_req = 1; inst_addr = 32'h1FC00100;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("t3_hold_addr", mem_addr, 32'hBFAF8000);
      advance();
    end
    mem_addr_ok = 1;
    settle();
    chk("t3_data_acc", {31'b0, data_addr_ok}, 32'h1);
    advance();
    data_req = 0;
    settle();
    chk("t3_inst_acc", {31'b0, inst_addr_ok}, 32'h1);
    advance();
    drain(3);

    // stall with inst granted; data must not steal the port
    inst_req = 1; inst_addr = 32'h1FC00200;
    settle(); advance();
    data_req = 1; data_addr = 32'h80001000;
    settle();
    chk("t4_hold_inst", mem_addr, 32'h1FC00200);
    advance();
    mem_addr_ok = 1;
    settle();
    chk("t4_inst_acc", {31'b0, inst_addr_ok}, 32'h1);
    advance();
    inst_req = 0;
    settle();
    chk("t4_data_acc", {31'b0, data_addr_ok}, 32'h1);
    advance();
    drain(3);

    // starvation: d,d,d,i,d,d,d,i
    pat = 8'h77;
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    for (int i = 0; i < 8; i++) begin
      mem_rdata = $urandom;
      settle();
      chk("t5_order_data", {31'b0, data_addr_ok}, {31'b0, pat[i]});
      chk("t5_order_inst", {31'b0, inst_addr_ok}, {31'b0, ~pat[i]});
      advance();
    end
    drain(2);

    // fill, block on full, reopen after a pop, then wrap pointers
    inst_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'h1FC01000 + 32'(i * 4);
      settle();
      chk("t6_fill", {31'b0, inst_addr_ok}, 32'h1);
      advance();
    end
    settle();
    chk("t6_full_block", {31'b0, mem_req}, 32'h0);
    advance();
    mem_data_ok = 1; mem_rdata = 32'hA5A50000;
    settle();
    chk("t6_full_pop", {31'b0, mem_req}, 32'h0);
    advance();
    mem_data_ok = 0;
    settle();
    chk("t6_reopen", {31'b0, mem_req}, 32'h1);
    advance();
    mem_data_ok = 1;
    for (int i = 0; i < 9; i++) begin
      inst_addr = 32'h1FC02000 + 32'(i * 4);
      mem_rdata = 32'h5A000000 + 32'(i);
      settle();
      chk("t6_wrap_resp", {31'b0, inst_data_ok}, 32'h1);
      chk("t6_wrap_rdata", inst_rdata, 32'h5A000000 + 32'(i));
      advance();
    end
    drain(5);

    // reset with work in flight and inst holding the port
    data_req = 1; data_addr = 32'h80002000; mem_addr_ok = 1;
    settle(); advance();
    data_req = 0; inst_req = 1; inst_addr = 32'h1FC03000;
    settle(); advance();
    mem_addr_ok = 0; inst_addr = 32'h1FC03004;
    settle(); advance();
    idle();
    rst = 1;
    model_reset();
    settle();
    chk("t7_rst_mem_req", {31'b0, mem_req}, 32'h0);
    advance();
    rst = 0;
    mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("t7_stray_inst", {31'b0, inst_data_ok}, 32'h0);
    chk("t7_stray_data", {31'b0, data_data_ok}, 32'h0);
    advance();
    idle();
    inst_req = 1; data_req = 1; data_addr = 32'hBFAF8010; mem_addr_ok = 1;
    settle();
    chk("t7_unlocked", mem_addr, 32'hBFAF8010);
    advance();
    drain(2);

    // randomized traffic; requesters hold until accepted
    ip = 0; dp = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1;
        inst_addr = $urandom; inst_wdata = $urandom;
        inst_size = 2'($urandom_range(0, 3)); inst_wr = 1'($urandom_range(0, 1));
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1;
        data_addr = $urandom; data_wdata = $urandom;
        data_size = 2'($urandom_range(0, 3)); data_wr = 1'($urandom_range(0, 1));
      end
      inst_req = ip; data_req = dp;
      mem_addr_ok = 1'($urandom_range(0, 1));
      mem_data_ok = ($urandom_range(0, 9) < 4);
      mem_rdata = $urandom;
      settle();
      if (e_iaok) ip = 0;
      if (e_daok) dp = 0;
      advance();
    end
    drain(DEPTH + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
